// File: rtl/key_conditioner_pkg.sv
// rtl/key_conditioner_pkg.sv - shared types and constants for the key conditioner
package key_conditioner_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    KS_RELEASED    = 2'd0,
    KS_PRESS_CHK   = 2'd1,
    KS_PRESSED     = 2'd2,
    KS_RELEASE_CHK = 2'd3
  } key_state_t;

  // 20 ms debounce and 1 s hold at a 50 MHz clock
  localparam int KC_DEBOUNCE_50M = 1_000_000;
  localparam int KC_LONG_50M     = 50_000_000;

  // A key counts as held once a press has been accepted, including while a
  // release is still being qualified.
  function automatic logic kc_held(input key_state_t st);
    return (st == KS_PRESSED) || (st == KS_RELEASE_CHK);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - key pins and conditioned event bundle
interface key_conditioner_if #(
  parameter int NUM_KEYS = 2
);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;

  // Board / consumer side: drives the pins, observes the events
  modport master (
    output key_n,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  // Conditioner side
  modport slave (
    input  key_n,
    output key_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/key_conditioner_ch.sv
// rtl/key_conditioner_ch.sv - one key channel: synchronizer, debounce FSM, hold timer
module key_conditioner_ch
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_50M,
  parameter int LONG_CYCLES     = KC_LONG_50M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_ONE = HW'(1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       s;
  key_state_t state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       long_q, long_d;
  logic       long_done_q, long_done_d;

  assign s = sync2_q;

  // Two-flop synchronizer on the raw active-low pin
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // Debounce FSM with its stability counter and saturating hold counter
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    if (kc_held(state_q) && (hcnt_q != H_MAX)) begin
      hcnt_d = hcnt_q + H_ONE;
    end
    case (state_q)
      KS_RELEASED: begin
        if (!s) begin
          state_d = KS_PRESS_CHK;
          dcnt_d  = D_ONE;
        end
      end
      KS_PRESS_CHK: begin
        if (s) begin
          state_d = KS_RELEASED;
          dcnt_d  = '0;
        end else if (dcnt_q == D_MAX) begin
          state_d = KS_PRESSED;
          hcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      KS_PRESSED: begin
        if (s) begin
          state_d = KS_RELEASE_CHK;
          dcnt_d  = D_ONE;
        end
      end
      KS_RELEASE_CHK: begin
        if (!s) begin
          state_d = KS_PRESSED;
        end else if (dcnt_q == D_MAX) begin
          state_d = KS_RELEASED;
        end else begin
          dcnt_d = dcnt_q + D_ONE;
        end
      end
      default: begin
        state_d = KS_RELEASED;
        dcnt_d  = '0;
      end
    endcase
  end

  // Output events derived from the registered state one cycle after the
  // FSM moves, so every output comes straight from a flop.
  always_comb begin
    level_d     = kc_held(state_q);
    press_d     = level_d & ~level_q;
    release_d   = ~level_d & level_q;
    long_d      = level_d & (hcnt_q == H_MAX) & ~long_done_q;
    long_done_d = level_d & (long_done_q | long_d);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= KS_RELEASED;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      long_done_q <= long_done_d;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - multi-channel push-button conditioner top
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_50M,
  parameter int LONG_CYCLES     = KC_LONG_50M
) (
  input  logic             clk,
  input  logic             rst_n,
  key_conditioner_if.slave kif
);

  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;
  logic [NUM_KEYS-1:0] long_w;

  // One fully independent channel per key
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    key_conditioner_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_n        (kif.key_n[gi]),
      .key_level    (level_w[gi]),
      .press_pulse  (press_w[gi]),
      .release_pulse(release_w[gi]),
      .long_pulse   (long_w[gi])
    );
  end

  assign kif.key_level     = level_w;
  assign kif.press_pulse   = press_w;
  assign kif.release_pulse = release_w;
  assign kif.long_pulse    = long_w;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized and directed bench for key_conditioner
module tb_key_conditioner;

  localparam int D = 4;
  localparam int L = 20;

  logic clk;
  logic rst_n;

  key_conditioner_if #(.NUM_KEYS(2)) kif ();

  key_conditioner #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kif  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ecnt  = 0;

  // reference model state
  logic [D:0] win  [2];
  logic [2:0] pipe [2];
  logic [1:0] raw_lvl;
  logic [1:0] m_level, m_press, m_rel, m_long;
  logic [1:0] armed;
  int         since [2];

  // pulse bookkeeping for literal checks
  int press_cnt [2];
  int rel_cnt   [2];
  int long_cnt  [2];
  int press_at  [2];
  int rel_at    [2];
  int long_at   [2];
  int lvl0_cnt;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < 2; c++) begin
      win[c]   = '1;
      pipe[c]  = '0;
      since[c] = 0;
    end
    raw_lvl = '0;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    armed   = '0;
  endtask

  // A level is accepted after D+1 consecutive opposite raw samples and shows
  // up on the outputs three edges later; long fires L cycles after a press.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      logic prev;
      win[c] = {win[c][D-1:0], kif.key_n[c]};
      if (!raw_lvl[c] && (win[c] == '0))      raw_lvl[c] = 1'b1;
      else if (raw_lvl[c] && (win[c] == '1))  raw_lvl[c] = 1'b0;
      prev       = m_level[c];
      m_level[c] = pipe[c][2];
      pipe[c]    = {pipe[c][1:0], raw_lvl[c]};
      m_press[c] = m_level[c] & ~prev;
      m_rel[c]   = ~m_level[c] & prev;
      m_long[c]  = 1'b0;
      if (m_press[c]) begin
        since[c] = 0;
        armed[c] = 1'b1;
      end else if (armed[c]) begin
        since[c]++;
        if (m_rel[c]) armed[c] = 1'b0;
        else if (since[c] == L) begin
          m_long[c] = 1'b1;
          armed[c]  = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 2; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      press_at[c] = -1; rel_at[c] = -1; long_at[c] = -1;
    end
    lvl0_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // model advance on every active edge
  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else begin
        model_step();
        ecnt++;
      end
    end
  end

  // compare DUT against model and record pulse times
  initial begin
    forever begin
      @(negedge clk);
      chk("key_level", kif.key_level, m_level);
      chk("press_pulse", kif.press_pulse, m_press);
      chk("release_pulse", kif.release_pulse, m_rel);
      chk("long_pulse", kif.long_pulse, m_long);
      if (rst_n) begin
        for (int c = 0; c < 2; c++) begin
          if (kif.press_pulse[c])   begin press_cnt[c]++; press_at[c] = ecnt; end
          if (kif.release_pulse[c]) begin rel_cnt[c]++;   rel_at[c]   = ecnt; end
          if (kif.long_pulse[c])    begin long_cnt[c]++;  long_at[c]  = ecnt; end
        end
        if (kif.key_level[0]) lvl0_cnt++;
      end
    end
  end

  initial begin
    int base;
    int run_left [2];
    logic [1:0] k;

    rst_n     = 1'b0;
    kif.key_n = 2'b00;
    clear_counts();

    // reset with both keys held
    tick(3);
    chk("rst_level", kif.key_level, 2'b00);
    chk("rst_press", kif.press_pulse, 2'b00);
    chk("rst_release", kif.release_pulse, 2'b00);
    chk("rst_long", kif.long_pulse, 2'b00);
    #1 rst_n = 1'b1;
    base = ecnt + 1;
    tick(12);
    chki("rst_press_at0", press_at[0], base + 7);
    chki("rst_press_at1", press_at[1], base + 7);
    chki("rst_press_cnt0", press_cnt[0], 1);
    chk("rst_level_after", kif.key_level, 2'b11);
    kif.key_n = 2'b11;
    tick(30);

    // clean press / long / release on key 0
    clear_counts();
    kif.key_n = 2'b10;
    base = ecnt + 1;
    tick(30);
    kif.key_n = 2'b11;
    tick(20);
    chki("clean_press_at", press_at[0], base + 7);
    chki("clean_long_at", long_at[0], base + 27);
    chki("clean_release_at", rel_at[0], base + 37);
    chki("clean_press_cnt", press_cnt[0], 1);
    chki("clean_long_cnt", long_cnt[0], 1);
    chki("clean_release_cnt", rel_cnt[0], 1);
    chki("clean_key1_quiet", press_cnt[1], 0);

    // press bounce
    clear_counts();
    kif.key_n = 2'b10; tick(3);
    kif.key_n = 2'b11; tick(1);
    kif.key_n = 2'b10; tick(3);
    kif.key_n = 2'b11; tick(15);
    chki("bounce_no_press", press_cnt[0], 0);
    chki("bounce_level_low", lvl0_cnt, 0);
    kif.key_n = 2'b10;
    base = ecnt + 1;
    tick(10);
    // release bounce while held
    kif.key_n = 2'b11; tick(3);
    kif.key_n = 2'b10; tick(30);
    chki("bounce_press_cnt", press_cnt[0], 1);
    chki("bounce_press_at", press_at[0], base + 7);
    chki("rbounce_no_release", rel_cnt[0], 0);
    chki("rbounce_long_cnt", long_cnt[0], 1);
    chki("rbounce_long_at", long_at[0], base + 27);
    chk("rbounce_level", kif.key_level, 2'b01);
    kif.key_n = 2'b11;
    tick(20);

    // simultaneous keys
    clear_counts();
    kif.key_n = 2'b00;
    base = ecnt + 1;
    tick(12);
    chki("simul_press_at0", press_at[0], base + 7);
    chki("simul_press_at1", press_at[1], base + 7);
    kif.key_n = 2'b10;
    base = ecnt + 1;
    tick(12);
    chki("simul_rel_cnt1", rel_cnt[1], 1);
    chki("simul_rel_at1", rel_at[1], base + 7);
    chki("simul_rel_cnt0", rel_cnt[0], 0);
    kif.key_n = 2'b11;
    tick(20);

    // reset during press debounce with key 1 already held
    kif.key_n = 2'b01;
    tick(12);
    kif.key_n = 2'b00;
    tick(5);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_level", kif.key_level, 2'b00);
    chk("midrst_press", kif.press_pulse, 2'b00);
    tick(2);
    clear_counts();
    #1 rst_n = 1'b1;
    base = ecnt + 1;
    tick(12);
    chki("midrst_press_at0", press_at[0], base + 7);
    chki("midrst_press_at1", press_at[1], base + 7);
    chki("midrst_press_cnt0", press_cnt[0], 1);
    kif.key_n = 2'b11;
    tick(20);

    // randomized runs, short and long, with one reset in the middle
    run_left[0] = 1;
    run_left[1] = 1;
    k = kif.key_n;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        run_left[c]--;
        if (run_left[c] <= 0) begin
          k[c] = ~k[c];
          if ($urandom_range(0, 3) == 0) run_left[c] = int'($urandom_range(20, 40));
          else                           run_left[c] = int'($urandom_range(1, 7));
        end
      end
      kif.key_n = k;
      if (cyc == 2000) begin
        #1 rst_n = 1'b0;
        tick(2);
        #1 rst_n = 1'b1;
      end
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Multi-channel push-button front end for the stopwatch and other DE-board designs. It synchronizes raw active-low key inputs to `clk`, debounces each one, and emits one-cycle press, release and long-press pulses plus a clean level. The stopwatch control FSM consumes `press_pulse` for start/pause and clear. `long_pulse` is available for hold-to-clear.

## Interface
- `NUM_KEYS`, default 2: number of independent key channels; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles required to accept a level change (20 ms at 50 MHz); must be ≥ 1.
- `LONG_CYCLES`, default 50_000_000: hold time after an accepted press before `long_pulse` fires (1 s); must be > `DEBOUNCE_CYCLES`.
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `key_n`, input, `NUM_KEYS`: raw key pins, asynchronous, 0 = pressed.
- `key_level`, output, `NUM_KEYS`: debounced level, 1 = pressed.
- `press_pulse`, output, `NUM_KEYS`: one-cycle pulse on an accepted press.
- `release_pulse`, output, `NUM_KEYS`: one-cycle pulse on an accepted release.
- `long_pulse`, output, `NUM_KEYS`: one-cycle pulse, at most once per press.

## Operation
- Channels are fully independent. Bit i of every output belongs only to `key_n[i]`.
- **Synchronizer.** Each key passes through a 2-flop synchronizer; both flops reset to 1. Its output is called `s`.
- **FSM states:** RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
- **RELEASED:**
  - `s`=0 → PRESS_CHK, with `dcnt`=1.
- **PRESS_CHK:**
  - `s`=1 → RELEASED, `dcnt` cleared.
  - `s`=0 and `dcnt`==`DEBOUNCE_CYCLES` → PRESSED. `press_pulse` is set for 1 cycle, `key_level` becomes 1, `hcnt` is cleared.
  - Otherwise `dcnt`++.
- **PRESSED:**
  - `hcnt` increments each cycle and saturates at `LONG_CYCLES`.
  - `long_pulse` fires on the cycle `hcnt` first reaches `LONG_CYCLES`.
  - `s`=1 → RELEASE_CHK, with `dcnt`=1.
- **RELEASE_CHK:**
  - `hcnt` keeps running.
  - `s`=0 → PRESSED, with no new `press_pulse` and `hcnt` not cleared.
  - `s`=1 and `dcnt`==`DEBOUNCE_CYCLES` → RELEASED. `release_pulse` is set for 1 cycle and `key_level` becomes 0.
  - Otherwise `dcnt`++.
- **Long-press reporting:** `long_pulse` may fire while in RELEASE_CHK. It fires at most once between a `press_pulse` and the following `release_pulse`.
- **Counter widths:**
  - `dcnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - `hcnt` is `$clog2(LONG_CYCLES+1)` bits.
  - Neither counter may wrap.
- **Glitches:** any excursion shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.

## Timing
- **Reset values:** all outputs are 0, all FSMs are RELEASED, synchronizer flops are 1, and counters are 0.
- **Press latency:**
  - `key_n[i]` falls and is stable from sampling edge 0.
  - `press_pulse[i]` and `key_level[i]` rise after edge `DEBOUNCE_CYCLES`+3.
  - `press_pulse[i]` falls after the next edge.
- **Release latency:** symmetric to press; `release_pulse` rises after edge `DEBOUNCE_CYCLES`+3 from the rising sample.
- **Long-press latency:** `long_pulse` is asserted exactly `LONG_CYCLES` cycles after `press_pulse`, provided no accepted release occurs before then.
- **Registered outputs:** every output is driven from a register, with no combinational path from `key_n`.
- **Pulse spacing:** pulses on one channel are mutually exclusive in a cycle. Different channels may pulse in the same cycle.
- **Reset mid-operation:**
  - All state is dropped immediately and no pulses are emitted.
  - A key still held at reset release is treated as a new press, with `press_pulse` at `DEBOUNCE_CYCLES`+3.

## Structure
- `key_conditioner_pkg`:
  - `key_state_t`, a 2-bit enum of the four states.
  - Default constants `KC_DEBOUNCE_50M`=1_000_000 and `KC_LONG_50M`=50_000_000.
- Sub-module `key_conditioner_ch`: one channel containing the synchronizer, FSM, `dcnt`, `hcnt` and output registers.
- Top level: a generate loop of `NUM_KEYS` instances of `key_conditioner_ch`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=20.
- **Reset:** hold `rst_n`=0 with `key_n`=2'b00 → all outputs 0. Release reset → `press_pulse`=2'b11 after edge 7, 1 cycle wide, and `key_level`=2'b11.
- **Clean press/release:** `key_n[0]` low for 30 cycles, then high.
  - `press_pulse[0]` after edge 7.
  - `long_pulse[0]` exactly 20 cycles later.
  - `release_pulse[0]` 7 edges after the rise.
  - Exactly one of each pulse.
- **Bounce:** `key_n[0]` low for 3 cycles, high for 1, low for 3, high → no pulses and `key_level` stays 0. Then low for 10 cycles → exactly one `press_pulse`.
- **Release bounce:** while pressed, `key_n[0]` high for 3 cycles then low → no `release_pulse` and `key_level` stays 1. Hold until `long_pulse`; it fires once on schedule with `hcnt` uninterrupted.
- **Simultaneous keys:** both keys fall on the same edge → `press_pulse`=2'b11 in one cycle. Key 1 released while key 0 held → only `release_pulse[1]`.
- **Reset mid-debounce:** assert `rst_n` in PRESS_CHK at `dcnt`=3 → outputs 0 immediately. After reset release with the key held → press at edge 7, not earlier.
